// File: rtl/des_pkg.sv
// Shared DES permutation definitions: block width, mode encoding and the
// standard FP (IP^-1) and IP tables as 1-based source positions.
package des_pkg;

    localparam int BLOCK_W = 64;

    typedef enum logic {
        PERM_FP = 1'b0,
        PERM_IP = 1'b1
    } perm_mode_e;

    // Entry i gives the 1-based input position that feeds output bit i.
    localparam int FP_TABLE [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32,
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25
    };

    localparam int IP_TABLE [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2,
        60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6,
        64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1,
        59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,
        63, 55, 47, 39, 31, 23, 15,  7
    };

    function automatic logic [2:0] count_valid(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/des_perm64.sv
// Combinational 64-bit DES bit permutation, FP or IP selected by mode.
// Pure wiring from the package tables; no state.
module des_perm64
    import des_pkg::*;
(
    input  perm_mode_e         mode,
    input  logic [BLOCK_W-1:0] data,
    output logic [BLOCK_W-1:0] perm
);

    logic [BLOCK_W-1:0] fp_bits;
    logic [BLOCK_W-1:0] ip_bits;

    for (genvar gi = 0; gi < BLOCK_W; gi++) begin : g_bit
        localparam logic [5:0] FP_SRC = 6'(FP_TABLE[gi] - 1);
        localparam logic [5:0] IP_SRC = 6'(IP_TABLE[gi] - 1);
        assign fp_bits[gi] = data[FP_SRC];
        assign ip_bits[gi] = data[IP_SRC];
    end

    assign perm = (mode == PERM_IP) ? ip_bits : fp_bits;

endmodule

// File: rtl/des_perm_pipe.sv
// Pipelined, valid/ready DES FP/IP permutation engine with tag sideband,
// flush and occupancy. Permutation sits in front of stage 0.
module des_perm_pipe
    import des_pkg::*;
#(
    parameter int PIPE_STAGES = 2,  // 1..4
    parameter int TAG_W       = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_mode,
    input  logic [BLOCK_W-1:0] in_data,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic [2:0]         occupancy
);

    logic               valid_reg [PIPE_STAGES];
    logic [BLOCK_W-1:0] data_reg  [PIPE_STAGES];
    logic [TAG_W-1:0]   tag_reg   [PIPE_STAGES];

    logic [PIPE_STAGES-1:0] valid_vec;
    logic [PIPE_STAGES-1:0] stage_ready;
    logic [BLOCK_W-1:0]     perm_data;

    des_perm64 u_perm (
        .mode (perm_mode_e'(in_mode)),
        .data (in_data),
        .perm (perm_data)
    );

    for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
        logic               src_valid;
        logic [BLOCK_W-1:0] src_data;
        logic [TAG_W-1:0]   src_tag;

        if (gi == 0) begin : g_first
            assign src_valid = in_valid;
            assign src_data  = perm_data;
            assign src_tag   = in_tag;
        end else begin : g_next
            assign src_valid = valid_reg[gi-1];
            assign src_data  = data_reg[gi-1];
            assign src_tag   = tag_reg[gi-1];
        end

        assign valid_vec[gi] = valid_reg[gi];
        // A stage can load unless it and every stage after it are full and
        // the output is stalled; bubbles therefore absorb stalls.
        assign stage_ready[gi] = out_ready | ~(&valid_vec[PIPE_STAGES-1:gi]);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_reg[gi] <= 1'b0;
                data_reg[gi]  <= '0;
                tag_reg[gi]   <= '0;
            end else begin
                if (flush) begin
                    valid_reg[gi] <= 1'b0;
                end else if (stage_ready[gi]) begin
                    valid_reg[gi] <= src_valid;
                end
                if (stage_ready[gi] && src_valid) begin
                    data_reg[gi] <= src_data;
                    tag_reg[gi]  <= src_tag;
                end
            end
        end
    end

    assign in_ready  = stage_ready[0] & ~flush;
    assign out_valid = valid_reg[PIPE_STAGES-1];
    assign out_data  = data_reg[PIPE_STAGES-1];
    assign out_tag   = tag_reg[PIPE_STAGES-1];
    assign occupancy = count_valid(4'(valid_vec));

endmodule

// File: tb/tb_des_perm_pipe.sv
// Directed self-checking bench for des_perm_pipe: one-hot sweeps, round trip,
// backpressure, flush and asynchronous reset.
module tb_des_perm_pipe;

    localparam int STAGES = 2;
    localparam int TW     = 4;
    localparam int NRT    = 1000;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic          in_mode;
    logic [63:0]   in_data;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_data;
    logic [TW-1:0] out_tag;
    logic [2:0]    occupancy;

    des_perm_pipe #(.PIPE_STAGES(STAGES), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0]   exp_data_q [$];
    logic [TW-1:0] exp_tag_q  [$];
    logic [63:0]   rx_q       [$];
    logic [63:0]   or_acc;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", name, got, exp);
        else
            n_pass++;
    endtask

    // Table model built from the arithmetic structure of the DES tables.
    function automatic logic [63:0] model(input logic mode, input logic [63:0] d);
        logic [63:0] res;
        int r, c, src;
        for (int i = 0; i < 64; i++) begin
            r = i / 8;
            c = i % 8;
            if (mode)
                src = ((r < 4) ? (58 + 2 * r) : (57 + 2 * (r - 4))) - 8 * c;
            else
                src = (((c % 2) == 0) ? 40 : 8) + 8 * (c / 2) - r;
            res[i] = d[src-1];
        end
        return res;
    endfunction

    // Output monitor: every output transfer is scored in order.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_data_q.size() == 0) begin
                chk("unexpected_output", 64'(out_valid), 64'd0);
            end else begin
                chk("out_data", out_data, exp_data_q.pop_front());
                chk("out_tag", 64'(out_tag), 64'(exp_tag_q.pop_front()));
            end
            rx_q.push_back(out_data);
            or_acc = or_acc | out_data;
        end
    end

    task automatic send(input logic mode, input logic [63:0] d, input logic [TW-1:0] t,
                        input bit keep, input logic [63:0] exp_d);
        int  waits = 0;
        bit  acc   = 0;
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = d;
        in_tag   = t;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            if (acc && keep) begin
                exp_data_q.push_back(exp_d);
                exp_tag_q.push_back(t);
            end
            @(posedge clk);
            #1;
            waits++;
            if (!acc && waits > 100) begin
                chk("send_timeout", 64'(acc), 64'd1);
                acc = 1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_data_q.size() != 0 || occupancy != 3'd0) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", 64'(exp_data_q.size() == 0 && occupancy == 3'd0), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [63:0] orig [NRT];
    logic [63:0] mid  [NRT];
    logic [63:0] one;
    logic [63:0] d1, d2, d3;
    int          lat;
    time         t0;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_mode = 1'b0;
        in_data = '0; in_tag = '0; out_ready = 1'b1; or_acc = '0;
        one = 64'h1;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Single-bit FP and IP with hand-derived results and latency
        send(1'b0, 64'h1, 4'h3, 1, 64'h0200_0000_0000_0000);
        wait_out(lat);
        chk("fp_latency", 64'(lat), 64'(STAGES));
        chk("fp_bit0", out_data, 64'h0200_0000_0000_0000);
        @(posedge clk); #1;
        send(1'b1, 64'h1, 4'h5, 1, 64'h0000_0080_0000_0000);
        wait_out(lat);
        chk("ip_latency", 64'(lat), 64'(STAGES));
        chk("ip_bit0", out_data, 64'h0000_0080_0000_0000);
        @(posedge clk); #1;
        drain();

        // One-hot sweeps: each output matches the table and all 64 are covered
        for (int m = 0; m < 2; m++) begin
            or_acc = '0;
            for (int i = 0; i < 64; i++)
                send(m[0], one << i, 4'(i), 1, model(m[0], one << i));
            drain();
            chk(m == 0 ? "fp_onehot_cover" : "ip_onehot_cover", or_acc, 64'hFFFF_FFFF_FFFF_FFFF);
        end

        // Round trip with alternating modes at full throughput
        rx_q.delete();
        for (int i = 0; i < NRT; i++) orig[i] = {$urandom(), $urandom()};
        t0 = $time;
        for (int i = 0; i < NRT; i++)
            send(i[0], orig[i], 4'(i), 1, model(i[0], orig[i]));
        chk("rt_throughput", 64'(($time - t0) / 10), 64'(NRT));
        drain();
        chk("rt_mid_count", 64'(rx_q.size()), 64'(NRT));
        for (int i = 0; i < NRT; i++) mid[i] = rx_q[i];
        for (int i = 0; i < NRT; i++)
            send(~i[0], mid[i], 4'(i), 1, orig[i]);
        drain();

        // Backpressure: full pipe, 10 stalled cycles, then release
        d1 = 64'h0123_4567_89AB_CDEF;
        d2 = 64'hFEDC_BA98_7654_3210;
        d3 = 64'hA5A5_5A5A_F00F_0FF0;
        out_ready = 1'b0;
        send(1'b0, d1, 4'h1, 1, model(1'b0, d1));
        send(1'b1, d2, 4'h2, 1, model(1'b1, d2));
        in_valid = 1'b1; in_mode = 1'b0; in_data = d3; in_tag = 4'h3;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_occupancy", 64'(occupancy), 64'(STAGES));
            chk("bp_out_stable", out_data, model(1'b0, d1));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        exp_data_q.push_back(model(1'b0, d3));
        exp_tag_q.push_back(4'h3);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("bp_stream", 64'(out_valid), 64'd1);
            @(posedge clk); #1;
        end
        drain();

        // Flush with two blocks in flight; block offered in flush cycle dropped
        out_ready = 1'b0;
        send(1'b0, d1, 4'h7, 0, 64'd0);
        send(1'b1, d2, 4'h8, 0, 64'd0);
        flush = 1'b1; in_valid = 1'b1; in_mode = 1'b1; in_data = d3; in_tag = 4'h9;
        @(negedge clk);
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_occupancy", 64'(occupancy), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("flush_no_ghost", 64'(out_valid), 64'd0);
            @(posedge clk); #1;
        end

        // Flush together with an output transfer: that transfer completes
        out_ready = 1'b0;
        send(1'b1, d3, 4'hA, 1, model(1'b1, d3));
        send(1'b0, d2, 4'hB, 0, 64'd0);
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flushout_done", 64'(exp_data_q.size()), 64'd0);
        chk("flushout_occupancy", 64'(occupancy), 64'd0);
        chk("flushout_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;

        // Asynchronous reset between edges while full
        out_ready = 1'b0;
        send(1'b0, d1, 4'hC, 0, 64'd0);
        send(1'b1, d2, 4'hD, 0, 64'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_occupancy", 64'(occupancy), 64'd0);
        chk("arst_out_data", out_data, 64'd0);
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(1'b1, d3, 4'hE, 1, model(1'b1, d3));
        wait_out(lat);
        chk("arst_latency", 64'(lat), 64'(STAGES));
        @(posedge clk); #1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
